ntt_bram_seq: RTL and testbench

Parametrised BRAM-to-NTT sequencer: on a start request it streams N words out of a block RAM into a local input buffer, launches an external NTT core, captures the core's N-word result and writes it back to a second BRAM region, then signals completion. It sits between the PS-visible BRAM port and the `ntt` compute core. It generalises the fixed 64-point loader with four additions: configurable size and latency, runtime base addresses, an explicit start/busy/done handshake, and a single-port FSM that never overlaps reads and writes.

---
 rtl/ntt_bram_seq_if.sv | 38 +++
 rtl/ntt_bram_seq.sv | 164 ++++++++++++++++
 tb/tb_ntt_bram_seq.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_bram_seq_if.sv
// Bus bundle between the BRAM/NTT sequencer and its environment: the
// start/busy/done handshake, the NTT core launch/result path and the BRAM port.
interface ntt_bram_seq_if #(
    parameter int unsigned N      = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 12
);
    logic                start;
    logic [ADDR_W-1:0]   src_base;
    logic [ADDR_W-1:0]   dst_base;
    logic                busy;
    logic                done;
    logic                core_start;
    logic [N*DATA_W-1:0] core_x;
    logic                core_done;
    logic [N*DATA_W-1:0] core_y;
    logic [ADDR_W-1:0]   BRAM_addr;
    logic                BRAM_clk;
    logic [DATA_W-1:0]   BRAM_din;
    logic [DATA_W-1:0]   BRAM_dout;
    logic                BRAM_en;
    logic                BRAM_rst;
    logic                BRAM_we;

    // Environment side: host control, NTT core model and BRAM.
    modport master (
        output start, src_base, dst_base, core_done, core_y, BRAM_dout,
        input  busy, done, core_start, core_x,
        input  BRAM_addr, BRAM_clk, BRAM_din, BRAM_en, BRAM_rst, BRAM_we
    );

    // Sequencer side.
    modport slave (
        input  start, src_base, dst_base, core_done, core_y, BRAM_dout,
        output busy, done, core_start, core_x,
        output BRAM_addr, BRAM_clk, BRAM_din, BRAM_en, BRAM_rst, BRAM_we
    );
endinterface

// File: rtl/ntt_bram_seq.sv
// BRAM-to-NTT sequencer: loads N words from BRAM into core_x, launches the
// NTT core, captures its result and writes it back to a second BRAM region.
// A single BRAM port is used; reads and writes never overlap.
module ntt_bram_seq #(
    parameter int unsigned N          = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned BYTE_SHIFT = 2,
    parameter int unsigned RD_LAT     = 1
) (
    input logic           clk,
    input logic           rst,
    ntt_bram_seq_if.slave bus
);
    // One counter walks both the LOAD issue/drain phase and the STORE phase.
    localparam int unsigned CNT_W = $clog2(N + RD_LAT + 1);
    localparam int unsigned IDX_W = $clog2(N);
    localparam logic [CNT_W-1:0] LastWord  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] LastDrain = CNT_W'(N + RD_LAT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StStore,
        StFin
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     first_q, first_d;
    logic [ADDR_W-1:0]        src_q, dst_q;
    logic [N-1:0][DATA_W-1:0] x_q;
    logic [N-1:0][DATA_W-1:0] y_q;
    // Read-return tracker: valid bit and word index of each read in flight.
    logic [RD_LAT-1:0]             pipe_v_q;
    logic [RD_LAT-1:0][IDX_W-1:0]  pipe_k_q;

    logic              accept;
    logic              issue;
    logic              capture_y;
    logic [ADDR_W-1:0] word_idx;

    // Next-state logic and all control outputs, decoded from the current state.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        first_d        = 1'b0;
        accept         = 1'b0;
        issue          = 1'b0;
        capture_y      = 1'b0;
        word_idx       = '0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        bus.core_start = 1'b0;
        bus.BRAM_en    = 1'b0;
        bus.BRAM_we    = 1'b0;
        bus.BRAM_addr  = '0;
        bus.BRAM_din   = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                bus.busy = 1'b1;
                word_idx = src_q + ADDR_W'(cnt_q);
                // Counts past LastWord are drain cycles with the port idle.
                if (cnt_q <= LastWord) begin
                    issue         = 1'b1;
                    bus.BRAM_en   = 1'b1;
                    bus.BRAM_addr = word_idx << BYTE_SHIFT;
                end
                if (cnt_q == LastDrain) begin
                    cnt_d   = '0;
                    first_d = 1'b1;
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StRun: begin
                bus.busy       = 1'b1;
                bus.core_start = first_q;
                // A result in the launch cycle itself is accepted.
                if (bus.core_done) begin
                    capture_y = 1'b1;
                    cnt_d     = '0;
                    state_d   = StStore;
                end
            end
            StStore: begin
                bus.busy      = 1'b1;
                bus.BRAM_en   = 1'b1;
                bus.BRAM_we   = 1'b1;
                word_idx      = dst_q + ADDR_W'(cnt_q);
                bus.BRAM_addr = word_idx << BYTE_SHIFT;
                bus.BRAM_din  = y_q[cnt_q[IDX_W-1:0]];
                if (cnt_q == LastWord) begin
                    cnt_d   = '0;
                    state_d = StFin;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StFin: begin
                bus.done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state register and phase counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    // Datapath: latched bases, read-return alignment, input and output buffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q    <= '0;
            dst_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            pipe_v_q <= '0;
            pipe_k_q <= '0;
        end else begin
            if (accept) begin
                src_q <= bus.src_base;
                dst_q <= bus.dst_base;
            end
            pipe_v_q[0] <= issue;
            pipe_k_q[0] <= cnt_q[IDX_W-1:0];
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v_q[i] <= pipe_v_q[i-1];
                pipe_k_q[i] <= pipe_k_q[i-1];
            end
            // Read data returns exactly RD_LAT cycles after its issue cycle.
            if (pipe_v_q[RD_LAT-1]) begin
                x_q[pipe_k_q[RD_LAT-1]] <= bus.BRAM_dout;
            end
            if (capture_y) begin
                y_q <= bus.core_y;
            end
        end
    end

    assign bus.core_x   = x_q;
    assign bus.BRAM_clk = clk;
    assign bus.BRAM_rst = rst;
endmodule

// File: tb/tb_ntt_bram_seq.sv
// Bench for ntt_bram_seq: instance A (N=8, RD_LAT=1, core delay 2) and
// instance B (N=4, RD_LAT=3, core delay 0), each with a BRAM and core model.
module tb_ntt_bram_seq;
    localparam int unsigned NA = 8;
    localparam int unsigned LA = 1;
    localparam int unsigned CA = 2;
    localparam int unsigned NB = 4;
    localparam int unsigned LB = 3;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ntt_bram_seq_if #(.N(NA), .DATA_W(64), .ADDR_W(12)) bus_a ();
    ntt_bram_seq_if #(.N(NB), .DATA_W(64), .ADDR_W(12)) bus_b ();

    ntt_bram_seq #(.N(NA), .DATA_W(64), .ADDR_W(12), .BYTE_SHIFT(2), .RD_LAT(LA)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );
    ntt_bram_seq #(.N(NB), .DATA_W(64), .ADDR_W(12), .BYTE_SHIFT(2), .RD_LAT(LB)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct packed {
        logic [11:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t         exp_wr_a[$];
    wr_t         exp_wr_b[$];
    logic [11:0] exp_rd_a[$];
    logic [11:0] exp_rd_b[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // BRAM models; reset reloads the source images.
    logic [63:0] mem_a [1024];
    logic [63:0] mem_b [1024];
    logic [63:0] rd_a;
    logic [63:0] rd_b [3];

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) mem_a[k] <= 64'(k + 1);
        end else if (bus_a.BRAM_en && bus_a.BRAM_we) begin
            mem_a[bus_a.BRAM_addr[11:2]] <= bus_a.BRAM_din;
        end
        if (bus_a.BRAM_en && !bus_a.BRAM_we) rd_a <= mem_a[bus_a.BRAM_addr[11:2]];
    end
    assign bus_a.BRAM_dout = rd_a;

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) mem_b[k] <= 64'(k + 1);
            mem_b[1022] <= 64'h11;
            mem_b[1023] <= 64'h22;
        end else if (bus_b.BRAM_en && bus_b.BRAM_we) begin
            mem_b[bus_b.BRAM_addr[11:2]] <= bus_b.BRAM_din;
        end
        if (bus_b.BRAM_en && !bus_b.BRAM_we) rd_b[0] <= mem_b[bus_b.BRAM_addr[11:2]];
        rd_b[1] <= rd_b[0];
        rd_b[2] <= rd_b[1];
    end
    assign bus_b.BRAM_dout = rd_b[2];

    // NTT core models: y = 2*x, done CA cycles after core_start (A) or with it (B).
    int unsigned dly_a;
    logic        model_done_a, model_done_b;
    logic        force_done_a, force_done_b;

    always @(posedge clk) begin
        if (rst) dly_a <= 0;
        else if (bus_a.core_start) dly_a <= 1;
        else if (dly_a != 0 && dly_a < CA) dly_a <= dly_a + 1;
        else dly_a <= 0;
    end
    assign model_done_a    = (dly_a == CA);
    assign model_done_b    = bus_b.core_start;
    assign bus_a.core_done = model_done_a | force_done_a;
    assign bus_b.core_done = model_done_b | force_done_b;

    always_comb begin
        bus_a.core_y = '0;
        for (int k = 0; k < NA; k++) bus_a.core_y[k*64 +: 64] = bus_a.core_x[k*64 +: 64] << 1;
    end
    always_comb begin
        bus_b.core_y = '0;
        for (int k = 0; k < NB; k++) bus_b.core_y[k*64 +: 64] = bus_b.core_x[k*64 +: 64] << 1;
    end

    // Port monitors: pop the scoreboards on every read issue and write.
    logic        got_a, got_b;
    int          done_cnt_a = 0, done_cnt_b = 0;
    int unsigned done_cyc_a, done_cyc_b, cs_cyc_a, cs_cyc_b;

    always @(negedge clk) begin
        if (rst) begin
            got_a <= 1'b0;
        end else begin
            if (model_done_a) got_a <= 1'b1;
            if (bus_a.core_start) cs_cyc_a <= cyc;
            if (bus_a.BRAM_en && !bus_a.BRAM_we) begin
                check("a_rd_expected", exp_rd_a.size() != 0, 1);
                if (exp_rd_a.size() != 0) begin
                    check("a_rd_addr", bus_a.BRAM_addr, exp_rd_a[0]);
                    void'(exp_rd_a.pop_front());
                end
            end
            if (bus_a.BRAM_en && bus_a.BRAM_we) begin
                check("a_wr_after_core_done", got_a, 1);
                check("a_wr_expected", exp_wr_a.size() != 0, 1);
                if (exp_wr_a.size() != 0) begin
                    check("a_wr_addr", bus_a.BRAM_addr, exp_wr_a[0].addr);
                    check("a_wr_data", bus_a.BRAM_din, exp_wr_a[0].data);
                    void'(exp_wr_a.pop_front());
                end
            end
            if (bus_a.done) begin
                done_cnt_a <= done_cnt_a + 1;
                done_cyc_a <= cyc;
                got_a      <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            got_b <= 1'b0;
        end else begin
            if (model_done_b) got_b <= 1'b1;
            if (bus_b.core_start) cs_cyc_b <= cyc;
            if (bus_b.BRAM_en && !bus_b.BRAM_we) begin
                check("b_rd_expected", exp_rd_b.size() != 0, 1);
                if (exp_rd_b.size() != 0) begin
                    check("b_rd_addr", bus_b.BRAM_addr, exp_rd_b[0]);
                    void'(exp_rd_b.pop_front());
                end
            end
            if (bus_b.BRAM_en && bus_b.BRAM_we) begin
                check("b_wr_after_core_done", got_b, 1);
                check("b_wr_expected", exp_wr_b.size() != 0, 1);
                if (exp_wr_b.size() != 0) begin
                    check("b_wr_addr", bus_b.BRAM_addr, exp_wr_b[0].addr);
                    check("b_wr_data", bus_b.BRAM_din, exp_wr_b[0].data);
                    void'(exp_wr_b.pop_front());
                end
            end
            if (bus_b.done) begin
                done_cnt_b <= done_cnt_b + 1;
                done_cyc_b <= cyc;
                got_b      <= 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A transform over words 0..7 (= 1..8) into dst.
    task automatic push_a(input int unsigned dst);
        for (int k = 0; k < 8; k++) begin
            exp_rd_a.push_back(12'(4 * k));
            exp_wr_a.push_back('{addr: 12'(4 * (dst + k)), data: 64'(2 * (k + 1))});
        end
    endtask

    task automatic push_wr_b(input int unsigned dst, input logic [63:0] x0, input logic [63:0] x1,
                             input logic [63:0] x2, input logic [63:0] x3);
        exp_wr_b.push_back('{addr: 12'(4 * dst),       data: 2 * x0});
        exp_wr_b.push_back('{addr: 12'(4 * (dst + 1)), data: 2 * x1});
        exp_wr_b.push_back('{addr: 12'(4 * (dst + 2)), data: 2 * x2});
        exp_wr_b.push_back('{addr: 12'(4 * (dst + 3)), data: 2 * x3});
    endtask

    task automatic wait_done_a(input int bound, output int unsigned at);
        int base;
        base = done_cnt_a;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt_a != base) break;
        end
        check("a_done_seen", done_cnt_a != base, 1);
        check("a_fin_busy", bus_a.busy, 0);
        at = done_cyc_a;
    endtask

    task automatic wait_done_b(input int bound, output int unsigned at);
        int base;
        base = done_cnt_b;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt_b != base) break;
        end
        check("b_done_seen", done_cnt_b != base, 1);
        check("b_fin_busy", bus_b.busy, 0);
        at = done_cyc_b;
    endtask

    task automatic wait_we_a(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if (bus_a.BRAM_we) break;
        end
        check("a_store_seen", bus_a.BRAM_we, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t0, td, td2, td3;
        int          base;
        rst            = 1'b1;
        bus_a.start    = 1'b0;
        bus_a.src_base = '0;
        bus_a.dst_base = '0;
        bus_b.start    = 1'b0;
        bus_b.src_base = '0;
        bus_b.dst_base = '0;
        force_done_a   = 1'b0;
        force_done_b   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        check("a_rst_busy", bus_a.busy, 0);
        check("a_rst_done", bus_a.done, 0);
        check("a_rst_core_start", bus_a.core_start, 0);
        check("a_rst_en", bus_a.BRAM_en, 0);
        check("a_rst_we", bus_a.BRAM_we, 0);
        check("a_rst_addr", bus_a.BRAM_addr, 0);
        check("a_rst_din", bus_a.BRAM_din, 0);
        check("a_rst_core_x", |bus_a.core_x, 0);
        check("b_rst_busy", bus_b.busy, 0);
        check("b_rst_en", bus_b.BRAM_en, 0);

        // Basic transform: A, src=0, dst=16
        tick();
        push_a(16);
        bus_a.src_base = 12'd0;
        bus_a.dst_base = 12'd16;
        bus_a.start    = 1'b1;
        t0             = cyc;
        tick();
        bus_a.start = 1'b0;
        @(negedge clk);
        check("a_load_busy", bus_a.busy, 1);
        wait_done_a(60, td);
        check("a_latency", td - t0, 21);
        check("a_core_start_cyc", cs_cyc_a - t0, 10);
        for (int k = 0; k < 8; k++) check("a_core_x", bus_a.core_x[k*64 +: 64], 64'(k + 1));
        for (int k = 0; k < 8; k++) check("a_mem_out", mem_a[16 + k], 64'(2 * (k + 1)));

        // Ignored inputs: start in LOAD and STORE, core_done in LOAD
        tick();
        push_a(24);
        bus_a.src_base = 12'd0;
        bus_a.dst_base = 12'd24;
        bus_a.start    = 1'b1;
        t0             = cyc;
        base           = done_cnt_a;
        tick();
        bus_a.start = 1'b0;
        tick();
        bus_a.start    = 1'b1;
        bus_a.src_base = 12'd100;
        bus_a.dst_base = 12'd200;
        tick();
        bus_a.start  = 1'b0;
        force_done_a = 1'b1;
        tick();
        force_done_a = 1'b0;
        wait_we_a(40);
        tick();
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        wait_done_a(60, td);
        check("a_ign_latency", td - t0, 21);
        repeat (30) tick();
        check("a_ign_single_done", done_cnt_a - base, 1);
        check("a_ign_wr_drained", exp_wr_a.size(), 0);
        check("a_ign_rd_drained", exp_rd_a.size(), 0);
        for (int k = 0; k < 8; k++) check("a_ign_mem_out", mem_a[24 + k], 64'(2 * (k + 1)));

        // Reset mid-STORE at k=3
        bus_a.src_base = 12'd0;
        bus_a.dst_base = 12'd32;
        push_a(32);
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        wait_we_a(60);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_wr_a.delete();
        exp_rd_a.delete();
        @(negedge clk);
        #1;
        check("a_rrst_we", bus_a.BRAM_we, 0);
        check("a_rrst_en", bus_a.BRAM_en, 0);
        check("a_rrst_busy", bus_a.busy, 0);
        check("a_rrst_done", bus_a.done, 0);
        check("a_rrst_core_x", |bus_a.core_x, 0);

        // Clean transform after reset
        tick();
        push_a(48);
        bus_a.dst_base = 12'd48;
        bus_a.start    = 1'b1;
        t0             = cyc;
        tick();
        bus_a.start = 1'b0;
        wait_done_a(60, td);
        check("a_post_rst_latency", td - t0, 21);
        for (int k = 0; k < 8; k++) check("a_post_rst_core_x", bus_a.core_x[k*64 +: 64], 64'(k + 1));
        for (int k = 0; k < 8; k++) check("a_post_rst_mem", mem_a[48 + k], 64'(2 * (k + 1)));

        // Read latency 3: B, src=0, dst=32
        tick();
        for (int k = 0; k < 4; k++) exp_rd_b.push_back(12'(4 * k));
        push_wr_b(32, 64'd1, 64'd2, 64'd3, 64'd4);
        bus_b.src_base = 12'd0;
        bus_b.dst_base = 12'd32;
        bus_b.start    = 1'b1;
        t0             = cyc;
        tick();
        bus_b.start = 1'b0;
        wait_done_b(40, td);
        check("b_latency", td - t0, 13);
        check("b_core_start_cyc", cs_cyc_b - t0, 8);
        for (int k = 0; k < 4; k++) check("b_core_x", bus_b.core_x[k*64 +: 64], 64'(k + 1));

        // Address wrap: src=1022
        tick();
        exp_rd_b.push_back(12'hFF8);
        exp_rd_b.push_back(12'hFFC);
        exp_rd_b.push_back(12'h000);
        exp_rd_b.push_back(12'h004);
        push_wr_b(40, 64'h11, 64'h22, 64'd1, 64'd2);
        bus_b.src_base = 12'd1022;
        bus_b.dst_base = 12'd40;
        bus_b.start    = 1'b1;
        tick();
        bus_b.start = 1'b0;
        wait_done_b(40, td);
        check("b_wrap_x0", bus_b.core_x[0 +: 64], 64'h11);
        check("b_wrap_x1", bus_b.core_x[64 +: 64], 64'h22);
        check("b_wrap_x2", bus_b.core_x[128 +: 64], 64'd1);
        check("b_wrap_x3", bus_b.core_x[192 +: 64], 64'd2);
        check("b_wrap_rd_drained", exp_rd_b.size(), 0);

        // Back-to-back with start held high
        tick();
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) exp_rd_b.push_back(12'(4 * k));
            push_wr_b(60, 64'd1, 64'd2, 64'd3, 64'd4);
        end
        base           = done_cnt_b;
        bus_b.src_base = 12'd0;
        bus_b.dst_base = 12'd60;
        bus_b.start    = 1'b1;
        t0             = cyc;
        wait_done_b(40, td);
        wait_done_b(40, td2);
        wait_done_b(40, td3);
        tick();
        bus_b.start = 1'b0;
        check("b_b2b_first_latency", td - t0, 13);
        check("b_b2b_gap1", td2 - td, 14);
        check("b_b2b_gap2", td3 - td2, 14);
        repeat (30) tick();
        check("b_b2b_done_count", done_cnt_b - base, 3);
        check("b_wr_drained", exp_wr_b.size(), 0);
        check("b_rd_drained", exp_rd_b.size(), 0);
        check("a_wr_drained", exp_wr_a.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
